// File: rtl/axil_sram_responder.sv
// -----------------------------------------------------------------------------
// axil_sram_responder
//
// AXI4-Lite slave that fronts a word-addressed 32-bit SRAM. The read and write
// channels are served by two independent FSMs, so one read and one write can
// be in flight at the same time. Each transaction waits a programmable number
// of cycles before its response is presented. Accesses outside the window
// [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS) get SLVERR and never touch memory.
//
// Parameters
//   BASE_ADDR  byte address of word 0
//   MEM_WORDS  number of 32-bit words held
//   READ_LAT   cycles from AR accept edge to rvalid (1..255)
//   WRITE_LAT  cycles from the later of AW/W accept to bvalid (1..255)
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   arvalid/arready/araddr          read address channel
//   rvalid/rready/rdata/rresp       read data channel
//   awvalid/awready/awaddr          write address channel
//   wvalid/wready/wdata/wstrb       write data channel (wstrb[7:4] ignored)
//   bvalid/bready/bresp             write response channel
//
// Build option
//   AXIL_SRAM_RAND_LAT_EN  when defined, each read and write latency is loaded
//                          at accept time from an 8-bit Fibonacci LFSR
//                          (taps 8,6,5,4, seed 8'hA5) as lfsr[2:0]+1, and
//                          READ_LAT/WRITE_LAT are ignored.
// -----------------------------------------------------------------------------
module axil_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 1024,
  parameter int          READ_LAT  = 1,
  parameter int          WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  // read address channel
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  // read data channel
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  // write address channel
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  // write data channel
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  // write response channel
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  localparam int          IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] WORDS_U = MEM_WORDS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // A latency of 0 would wrap the down-counter, so clamp to the legal minimum.
  localparam logic [7:0] RD_LAT_C = (READ_LAT  < 1) ? 8'd1 : 8'(READ_LAT);
  localparam logic [7:0] WR_LAT_C = (WRITE_LAT < 1) ? 8'd1 : 8'(WRITE_LAT);

  logic [31:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Latency source
  // ---------------------------------------------------------------------------
  logic [7:0] rd_lat;
  logic [7:0] wr_lat;

`ifdef AXIL_SRAM_RAND_LAT_EN
  logic [7:0] lfsr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign rd_lat = {5'b0, lfsr[2:0]} + 8'd1;
  assign wr_lat = {5'b0, lfsr[2:0]} + 8'd1;
`else
  assign rd_lat = RD_LAT_C;
  assign wr_lat = WR_LAT_C;
`endif

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [31:0]      r_addr;
  logic [7:0]       r_cnt;
  logic [31:0]      r_off;
  logic             r_ok;
  logic [IDX_W-1:0] r_idx;

  // The subtraction wraps for addresses below BASE_ADDR, hence the explicit
  // lower-bound compare alongside the word-count compare.
  assign r_off = (r_addr - BASE_ADDR) >> 2;
  assign r_ok  = (r_addr >= BASE_ADDR) && (r_off < WORDS_U);
  assign r_idx = r_off[IDX_W-1:0];

  assign arready = (r_state == R_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_addr  <= araddr;
            r_cnt   <= rd_lat;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 8'd1) begin
            // Sampled with the pre-edge memory contents, so a write committing
            // on this same edge is not yet visible here.
            rvalid  <= 1'b1;
            rdata   <= r_ok ? mem[r_idx] : '0;
            rresp   <= r_ok ? RESP_OKAY : RESP_SLVERR;
            r_state <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic [1:0]       w_state;
  logic             aw_got;
  logic             w_got;
  logic [31:0]      w_addr;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic [7:0]       w_cnt;
  logic [31:0]      w_off;
  logic             w_ok;
  logic [IDX_W-1:0] w_idx;
  logic             w_due;
  logic             w_commit;
  logic             aw_fire;
  logic             w_fire;
  logic             unused_strb;

  assign unused_strb = ^wstrb[7:4];

  assign w_off = (w_addr - BASE_ADDR) >> 2;
  assign w_ok  = (w_addr >= BASE_ADDR) && (w_off < WORDS_U);
  assign w_idx = w_off[IDX_W-1:0];

  // Each channel's ready drops as soon as that channel alone has been captured.
  assign awready = (w_state == W_IDLE) && !aw_got;
  assign wready  = (w_state == W_IDLE) && !w_got;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  assign w_due = (w_state == W_WAIT) && (w_cnt == 8'd1);
  // Reset on the commit edge abandons the write rather than finishing it.
  assign w_commit = w_due && w_ok && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      w_cnt   <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            w_addr <= awaddr;
            aw_got <= 1'b1;
          end
          if (w_fire) begin
            w_data <= wdata;
            w_strb <= wstrb[3:0];
            w_got  <= 1'b1;
          end
          // Covers AW-then-W, W-then-AW and both on the same edge.
          if ((aw_got || aw_fire) && (w_got || w_fire)) begin
            w_cnt   <= wr_lat;
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_due) begin
            bvalid  <= 1'b1;
            bresp   <= w_ok ? RESP_OKAY : RESP_SLVERR;
            w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 8'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset branch; contents survive rst and the
  // array maps onto plain RAM instead of a bank of resettable flops.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) begin
          mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: doc/axil_sram_responder.md
AXIL_SRAM_RESPONDER -- requirements
Module: axil_sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words held.
REQ-003 SHALL have parameter READ_LAT, default 1 (minimum 1): cycles from AR accept edge to rvalid.
REQ-004 SHALL have parameter WRITE_LAT, default 1 (minimum 1): cycles from last of AW/W accept edge to bvalid.
REQ-005 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports arvalid in 1, arready out 1, araddr in 32: read address channel.
REQ-008 SHALL have ports rvalid out 1, rready in 1, rdata out 32, rresp out 2: read data channel.
REQ-009 SHALL have ports awvalid in 1, awready out 1, awaddr in 32: write address channel.
REQ-010 SHALL have ports wvalid in 1, wready out 1, wdata in 32, wstrb in 8: write data channel; wstrb[3:0] byte enables, wstrb[7:4] ignored.
REQ-011 SHALL have ports bvalid out 1, bready in 1, bresp out 2: write response channel.

Function
REQ-012 SHALL accept a channel transfer only on a rising edge where valid and ready are both high.
REQ-013 Read FSM SHALL have states R_IDLE, R_WAIT, R_RESP; arready SHALL be high only in R_IDLE.
REQ-014 On AR accept SHALL capture araddr, load latency counter, enter R_WAIT.
REQ-015 SHALL sample memory and assert rvalid exactly READ_LAT cycles after AR accept edge, entering R_RESP.
REQ-016 rvalid, rdata, rresp SHALL stay stable in R_RESP until rready; on rvalid&&rready SHALL return to R_IDLE next cycle.
REQ-017 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP; AW and W SHALL be accepted independently in W_IDLE, in either order or the same cycle.
REQ-018 awready (wready) SHALL be high in W_IDLE until its own channel is captured, then low until return to W_IDLE.
REQ-019 With both captured SHALL enter W_WAIT, commit the write WRITE_LAT cycles later, and assert bvalid the same edge.
REQ-020 Write commit SHALL update only bytes whose wstrb[3:0] bit is 1.
REQ-021 bvalid, bresp SHALL stay stable until bready; on bvalid&&bready SHALL return to W_IDLE.
REQ-022 Word index SHALL be (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
REQ-023 Address below BASE_ADDR or index >= MEM_WORDS: read SHALL return rdata=0, rresp=2'b10; write SHALL modify nothing, bresp=2'b10.
REQ-024 In-range transfers SHALL return rresp/bresp=2'b00.
REQ-025 Read and write FSMs SHALL run concurrently; if a write commits on the same edge a read samples the same word, the read SHALL return pre-write data.
REQ-026 SHALL hold at most one outstanding read and one outstanding write.

Reset
REQ-027 On rst SHALL enter R_IDLE and W_IDLE, clear captured flags and counters.
REQ-028 Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
REQ-029 Reset mid-transaction SHALL abandon it; an uncommitted write SHALL NOT modify memory.
REQ-030 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-031 Macro AXIL_SRAM_RAND_LAT_EN defined: read and write latencies SHALL each be loaded at accept from an 8-bit Fibonacci LFSR (taps 8,6,5,4, reset seed 8'hA5, advancing every cycle) as lfsr[2:0]+1 (range 1..8), ignoring READ_LAT/WRITE_LAT.
REQ-032 Macro undefined: latencies SHALL be exactly READ_LAT and WRITE_LAT; no LFSR logic present.

Verification
REQ-033 Write 32'hDEAD_BEEF to 32'h8000_0010, wstrb=8'h0F, then read same -> bresp=0, rdata=32'hDEAD_BEEF, rresp=0.
REQ-034 Prior word 32'h1122_3344, write 32'hAABB_CCDD wstrb=8'h05 -> read returns 32'h11BB_33DD.
REQ-035 W valid 2 cycles before AW, both to 32'h8000_0020 -> wready drops after W accept, bvalid exactly WRITE_LAT cycles after AW accept.
REQ-036 Read 32'h8000_1000 (MEM_WORDS=1024) -> rdata=0, rresp=2'b10; write same -> bresp=2'b10, memory unchanged.
REQ-037 rready held low 5 cycles after rvalid -> rvalid and rdata stable all 5 cycles, arready low until handshake.
REQ-038 rst asserted in W_WAIT -> bvalid stays 0, target word keeps old value, awready=wready=1 next cycle.
